// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: one UART receive lane.
// Synchronises the serial line, times each bit from a local baud counter,
// samples at mid-bit, assembles LSB-first data and hands each byte to the
// host through a one-entry valid/ready holding register with sticky errors.
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state and parity_odd_i).
module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx_i,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd_i,
`endif
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  input  logic                 err_clr_i,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] SAMPLE_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic sample_s, bit_end_s, last_bit_s;
  logic complete_s, handshake_s, load_s;
  logic ferr_set_s, perr_set_s, ovr_set_s;

  assign sample_s   = (cnt_q == SAMPLE_CNT);
  assign bit_end_s  = (cnt_q == BIT_END_CNT);
  assign last_bit_s = (bit_cnt_q == LAST_BIT);

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; STOP leaves at mid-bit to re-arm early for the next start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
        else         state_d = S_IDLE;
      end
      S_START: begin
        if (sample_s && rx_s_q) state_d = S_IDLE;
        else if (bit_end_s)     state_d = S_DATA;
        else                    state_d = S_START;
      end
      S_DATA: begin
        if (bit_end_s && last_bit_s) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) state_d = S_STOP;
        else           state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (sample_s) state_d = S_IDLE;
        else          state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output/datapath decode: baud and bit counters, shifter, holding register, flags.
  always_comb begin
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    complete_s   = 1'b0;
    perr_set_s   = 1'b0;

    // baud counter restarts on every state change and rests at 0 in IDLE
    if (state_d != state_q)     cnt_d = '0;
    else if (state_q == S_IDLE) cnt_d = '0;
    else if (bit_end_s)         cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);

    if (state_q == S_START && state_d == S_DATA) begin
      bit_cnt_d = '0;
    end else if (state_q == S_DATA && bit_end_s && !last_bit_s) begin
      bit_cnt_d = bit_cnt_q + BW'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    // line order is LSB first, so each new bit enters at the MSB
    if (state_q == S_DATA && sample_s) shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
    else                               shift_d = shift_q;

`ifdef UART_RX_PARITY_EN
    if (state_q == S_PARITY && sample_s) perr_set_s = (rx_s_q != (^shift_q ^ parity_odd_i));
    else                                 perr_set_s = 1'b0;
`endif

    if (state_q == S_STOP && sample_s) complete_s = 1'b1;
    else                               complete_s = 1'b0;
  end

  assign handshake_s = rx_valid_q & rx_ready_i;
  assign load_s      = complete_s & (~rx_valid_q | handshake_s);
  assign ovr_set_s   = complete_s & rx_valid_q & ~handshake_s;
  assign ferr_set_s  = complete_s & ~rx_s_q;

  // Holding register and sticky flags; a new error outranks a same-cycle clear.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;

    if (load_s) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (handshake_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (ferr_set_s)     frame_err_d = 1'b1;
    else if (err_clr_i) frame_err_d = 1'b0;
    else                frame_err_d = frame_err_q;

    if (perr_set_s)     parity_err_d = 1'b1;
    else if (err_clr_i) parity_err_d = 1'b0;
    else                parity_err_d = parity_err_q;

    if (ovr_set_s)      overrun_d = 1'b1;
    else if (err_clr_i) overrun_d = 1'b0;
    else                overrun_d = overrun_q;
  end

  // Counters, shifter, holding register and flag registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer (CLKS_PER_BIT=16, DATA_BITS=8).
module tb_uart_rx_sequencer;

  localparam int CPB = 16;

  logic       clk;
  logic       nrst;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       err_clr_i;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd_i;
`endif

  int vectors;
  int miscompares;
  int hs_cnt;
  logic [7:0] hs_data;
  int hs_base;

  uart_rx_sequencer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .rx_i         (rx_i),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i (parity_odd_i),
`endif
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o),
    .err_clr_i    (err_clr_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: a valid&ready seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (nrst && rx_valid_o && rx_ready_i) begin
      hs_cnt  = hs_cnt + 1;
      hs_data = rx_data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) tick();
  endtask

  // One frame: start, 8 data bits LSB first, optional parity, stop, then idle line.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (use_par) send_bit(par_bit);
    send_bit(stop_bit);
    rx_i = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hs_cnt      = 0;
    hs_data     = 8'h00;
    nrst        = 1'b0;
    rx_i        = 1'b1;
    rx_ready_i  = 1'b0;
    err_clr_i   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_odd_i = 1'b0;
`endif
    repeat (3) tick();

    // reset state
    chk("rst_data",   32'(rx_data_o),    32'h00);
    chk("rst_valid",  32'(rx_valid_o),   32'h0);
    chk("rst_ferr",   32'(frame_err_o),  32'h0);
    chk("rst_perr",   32'(parity_err_o), 32'h0);
    chk("rst_ovr",    32'(overrun_o),    32'h0);
    chk("rst_busy",   32'(busy_o),       32'h0);
    nrst = 1'b1;
    repeat (3) tick();

    // 1: clean 0xA5, host always ready -> exactly one handshake
    rx_ready_i = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("t1_hs_cnt",  32'(hs_cnt),       32'd1);
    chk("t1_data",    32'(hs_data),      32'hA5);
    chk("t1_valid",   32'(rx_valid_o),   32'h0);
    chk("t1_ferr",    32'(frame_err_o),  32'h0);
    chk("t1_ovr",     32'(overrun_o),    32'h0);
    chk("t1_perr",    32'(parity_err_o), 32'h0);

    // 2: 3-clk glitch is rejected at the start-bit sample point
    rx_i = 1'b0;
    repeat (3) tick();
    rx_i = 1'b1;
    tick();
    chk("t2_busy_hi", 32'(busy_o),       32'h1);
    repeat (20) tick();
    chk("t2_busy_lo", 32'(busy_o),       32'h0);
    chk("t2_valid",   32'(rx_valid_o),   32'h0);
    chk("t2_hs_cnt",  32'(hs_cnt),       32'd1);
    chk("t2_ferr",    32'(frame_err_o),  32'h0);

    // 3: bad stop bit -> data still delivered, frame error until cleared
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t3_hs_cnt",  32'(hs_cnt),       32'd2);
    chk("t3_data",    32'(hs_data),      32'h3C);
    chk("t3_dout",    32'(rx_data_o),    32'h3C);
    chk("t3_ferr",    32'(frame_err_o),  32'h1);
    chk("t3_busy",    32'(busy_o),       32'h0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t3_ferr_clr", 32'(frame_err_o), 32'h0);

    // 4: host stalled -> second byte overruns, first byte held
    rx_ready_i = 1'b0;
    hs_base = hs_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk("t4_valid1",  32'(rx_valid_o),   32'h1);
    chk("t4_data1",   32'(rx_data_o),    32'h11);
    chk("t4_ovr0",    32'(overrun_o),    32'h0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("t4_valid2",  32'(rx_valid_o),   32'h1);
    chk("t4_data2",   32'(rx_data_o),    32'h11);
    chk("t4_ovr1",    32'(overrun_o),    32'h1);
    chk("t4_ferr",    32'(frame_err_o),  32'h0);
    rx_ready_i = 1'b1;
    tick();
    chk("t4_valid_drop", 32'(rx_valid_o), 32'h0);
    chk("t4_hs_data",    32'(hs_data),    32'h11);
    chk("t4_hs_cnt",     32'(hs_cnt - hs_base), 32'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t4_ovr_clr", 32'(overrun_o),    32'h0);

`ifdef UART_RX_PARITY_EN
    // 5: even parity for 0x07 needs parity bit 1
    parity_odd_i = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    chk("t5_perr_bad",  32'(parity_err_o), 32'h1);
    chk("t5_data",      32'(hs_data),      32'h07);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t5_perr_clr",  32'(parity_err_o), 32'h0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    chk("t5_perr_good", 32'(parity_err_o), 32'h0);
`else
    chk("t5_perr_tied", 32'(parity_err_o), 32'h0);
`endif

    // 6: reset in the middle of data bit 4, then a clean 0x5A
    hs_base = hs_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_i = 1'b0;
    repeat (CPB / 2) tick();
    chk("t6_busy_pre", 32'(busy_o),      32'h1);
    nrst = 1'b0;
    rx_i = 1'b1;
    #1;
    chk("t6_rst_busy",  32'(busy_o),     32'h0);
    chk("t6_rst_data",  32'(rx_data_o),  32'h00);
    chk("t6_rst_valid", 32'(rx_valid_o), 32'h0);
    repeat (3) tick();
    nrst = 1'b1;
    repeat (5) tick();
    chk("t6_idle",     32'(busy_o),      32'h0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("t6_hs_cnt",   32'(hs_cnt - hs_base), 32'd1);
    chk("t6_data",     32'(hs_data),     32'h5A);
    chk("t6_ferr",     32'(frame_err_o), 32'h0);
    chk("t6_ovr",      32'(overrun_o),   32'h0);
    chk("t6_perr",     32'(parity_err_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
